// File: rtl/conware_pkg.sv
// Shared defaults and FSM encoding for the Game-of-Life cell-to-AXIS video path.
package conware_pkg;

  localparam int DEF_GRID_W        = 64;
  localparam int DEF_GRID_H        = 48;
  localparam int DEF_CELL_SIZE     = 10;
  localparam int DEF_ROW_ADDR_BITS = 6;
  localparam int DEF_DATA_WIDTH    = 32;

  localparam logic [31:0] DEF_ALIVE_COLOR = 32'h00FF_FFFF;
  localparam logic [31:0] DEF_DEAD_COLOR  = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_LATCH  = 2'd2,
    ST_STREAM = 2'd3
  } state_t;

  // Counter width for a modulo-n counter; a 1-state counter still needs a bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conware_axis_out_reg.sv
// Single-entry AXI4-Stream output register: loads a new beat whenever the
// current one is absent or being accepted, otherwise holds it untouched.
module conware_axis_out_reg #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  aclk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_user,
  input  logic                  in_last,
  output logic [DATA_WIDTH-1:0] tdata,
  output logic                  tvalid,
  input  logic                  tready,
  output logic                  tuser,
  output logic                  tlast
);

  assign in_ready = !tvalid || tready;

  always_ff @(posedge aclk) begin
    if (rst) begin
      tvalid <= 1'b0;
      tdata  <= '0;
      tuser  <= 1'b0;
      tlast  <= 1'b0;
    end else if (in_ready) begin
      tvalid <= in_valid;
      if (in_valid) begin
        tdata <= in_data;
        tuser <= in_user;
        tlast <= in_last;
      end
    end
  end

endmodule

// File: rtl/conware_cell_stream.sv
// Streams the cell grid as an AXIS video frame, one RAM row fetch per cell row,
// each cell scaled to CELL_SIZE x CELL_SIZE pixels.
//
//  state  | meaning
//  IDLE   | no frame in flight, waiting for enable
//  FETCH  | read strobe for cell_row issued to grid RAM
//  LATCH  | RAM data captured into row_reg
//  STREAM | pixels produced for all sub-lines of cell_row, then drain of last beat
module conware_cell_stream
  import conware_pkg::*;
#(
  parameter int GRID_W        = DEF_GRID_W,
  parameter int GRID_H        = DEF_GRID_H,
  parameter int CELL_SIZE     = DEF_CELL_SIZE,
  parameter int ROW_ADDR_BITS = DEF_ROW_ADDR_BITS,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] ALIVE_COLOR = DATA_WIDTH'(DEF_ALIVE_COLOR),
  parameter logic [DATA_WIDTH-1:0] DEAD_COLOR  = DATA_WIDTH'(DEF_DEAD_COLOR)
) (
  input  logic                     aclk,
  input  logic                     rst,
  input  logic                     enable,
  output logic                     cell_rd_en,
  output logic [ROW_ADDR_BITS-1:0] cell_rd_addr,
  input  logic [GRID_W-1:0]        cell_rd_data,
  output logic [DATA_WIDTH-1:0]    m_axis_video_tdata,
  output logic                     m_axis_video_tvalid,
  input  logic                     m_axis_video_tready,
  output logic                     m_axis_video_tuser,
  output logic                     m_axis_video_tlast,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int CX_W = cnt_w(GRID_W);
  localparam int CR_W = cnt_w(GRID_H);
  localparam int CS_W = cnt_w(CELL_SIZE);

  localparam logic [CX_W-1:0] CX_MAX = CX_W'(GRID_W - 1);
  localparam logic [CR_W-1:0] CR_MAX = CR_W'(GRID_H - 1);
  localparam logic [CS_W-1:0] CS_MAX = CS_W'(CELL_SIZE - 1);

  state_t state, state_nxt;

  logic [GRID_W-1:0]     row_reg;
  logic [CX_W-1:0]       cell_x;
  logic [CS_W-1:0]       sub_x;
  logic [CS_W-1:0]       sub_y;
  logic [CR_W-1:0]       cell_row;
  logic                  drain;

  logic                  pix_valid;
  logic                  pix_ready;
  logic                  pix_load;
  logic [DATA_WIDTH-1:0] pix_data;
  logic                  pix_user;
  logic                  x_end;
  logic                  row_done;
  logic                  last_accept;

  assign x_end     = (sub_x == CS_MAX) && (cell_x == CX_MAX);
  assign row_done  = x_end && (sub_y == CS_MAX);
  assign pix_valid = (state == ST_STREAM) && !drain;
  assign pix_load  = pix_valid && pix_ready;
  assign pix_data  = row_reg[cell_x] ? ALIVE_COLOR : DEAD_COLOR;
  assign pix_user  = (cell_x == '0) && (sub_x == '0) && (sub_y == '0) && (cell_row == '0);

  // The final beat of a frame may still be stalled downstream after the
  // counters wrapped; drain marks it so frame end waits for its handshake.
  assign last_accept = drain && m_axis_video_tvalid && m_axis_video_tready;
  assign frame_done  = last_accept;
  assign busy        = (state != ST_IDLE);
  assign cell_rd_en  = (state == ST_FETCH);
  assign cell_rd_addr = cell_rd_en ? ROW_ADDR_BITS'(cell_row) : '0;

  always_ff @(posedge aclk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (enable) state_nxt = ST_FETCH;
      ST_FETCH:  state_nxt = ST_LATCH;
      ST_LATCH:  state_nxt = ST_STREAM;
      ST_STREAM: begin
        if (pix_load && row_done && (cell_row != CR_MAX)) state_nxt = ST_FETCH;
        else if (last_accept) state_nxt = enable ? ST_FETCH : ST_IDLE;
      end
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      row_reg  <= '0;
      cell_x   <= '0;
      sub_x    <= '0;
      sub_y    <= '0;
      cell_row <= '0;
      drain    <= 1'b0;
    end else begin
      if (state == ST_LATCH) row_reg <= cell_rd_data;
      if (last_accept) drain <= 1'b0;
      if (pix_load) begin
        if (sub_x == CS_MAX) begin
          sub_x  <= '0;
          cell_x <= (cell_x == CX_MAX) ? '0 : cell_x + 1'b1;
        end else begin
          sub_x <= sub_x + 1'b1;
        end
        if (x_end) begin
          if (sub_y != CS_MAX) begin
            sub_y <= sub_y + 1'b1;
          end else begin
            sub_y <= '0;
            if (cell_row != CR_MAX) begin
              cell_row <= cell_row + 1'b1;
            end else begin
              cell_row <= '0;
              drain    <= 1'b1;
            end
          end
        end
      end
    end
  end

  conware_axis_out_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_reg (
    .aclk     (aclk),
    .rst      (rst),
    .in_valid (pix_valid),
    .in_ready (pix_ready),
    .in_data  (pix_data),
    .in_user  (pix_user),
    .in_last  (x_end),
    .tdata    (m_axis_video_tdata),
    .tvalid   (m_axis_video_tvalid),
    .tready   (m_axis_video_tready),
    .tuser    (m_axis_video_tuser),
    .tlast    (m_axis_video_tlast)
  );

endmodule
